// File: rtl/ws2812b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : ws2812b_pkg                                                   |
// | Purpose  : Shared constants for the WS2812B pixel feeder: register map,  |
// |            command-entry layout helpers and engine state encoding.       |
// | Entry    : {G[7:0], R[7:0], B[7:0], count[CNT_W-1:0], latch}             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ws2812b_pkg;

    // Register map
    localparam logic [3:0] ADDR_G      = 4'h0;
    localparam logic [3:0] ADDR_R      = 4'h1;
    localparam logic [3:0] ADDR_B      = 4'h2;
    localparam logic [3:0] ADDR_CMD    = 4'h3;  // write side
    localparam logic [3:0] ADDR_STATUS = 4'h3;  // read side
    localparam logic [3:0] ADDR_BRIGHT = 4'h4;
    localparam logic [3:0] ADDR_CLR    = 4'hF;

    localparam int DEF_CNT_W = 7;

    // Entry field offsets (LSB first)
    localparam int OFF_LATCH = 0;
    localparam int OFF_CNT   = 1;

    function automatic int entry_w(input int cnt_w);
        return 24 + cnt_w + 1;
    endfunction

    function automatic int off_rgb(input int cnt_w);
        return cnt_w + 1;
    endfunction

    localparam int ENTRY_W = entry_w(DEF_CNT_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ws2812b_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2812b_cmd_fifo                                              |
// | Purpose  : Synchronous command FIFO, asynchronous active-low reset.      |
// |            rdata presents the head entry whenever empty is low.          |
// |            A push into a full FIFO is accepted only when a pop happens   |
// |            in the same cycle.                                            |
// | Ports    : clk, rst_n, push, pop, wdata -> rdata, full, empty, level     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ws2812b_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812b_pixel_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2812b_pixel_feeder                                          |
// | Purpose  : Assembles byte-wide register writes into GRB pixel commands,  |
// |            queues them, and replays each as count+1 pixels over a        |
// |            valid/ready handshake to the WS2812B serializer.              |
// | Ports    : clk, rst_n, address[3:0], data_in[7:0], data_write           |
// |            -> data_out[7:0]; pix_data[23:0], pix_valid, pix_latch        |
// |            <- pix_ready                                                  |
// | Options  : WS2812B_FEED_BRIGHTNESS_EN adds BRIGHT register (addr 4) and  |
// |            scales each channel when a command is loaded.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ws2812b_pixel_feeder
    import ws2812b_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  address,
    input  logic [7:0]  data_in,
    input  logic        data_write,
    output logic [7:0]  data_out,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_latch,
    input  logic        pix_ready
);
    localparam int EW      = entry_w(CNT_W);
    localparam int RGB_OFF = off_rgb(CNT_W);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

    logic [7:0]       g_q, r_q, b_q;
    logic             ovf_q;
    state_t           state_q;
    logic [EW-1:0]    entry_q;
    logic [CNT_W-1:0] remain_q;
    logic             cur_latch_q;
    logic [23:0]      pix_data_q;
    logic             pix_valid_q;
    logic             pix_latch_q;

    logic             w_cmd_wr;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic [31:0]      w_level32;
    logic [2:0]       w_level_sat;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic [23:0]      w_load_rgb;
    logic [7:0]       w_ent_g, w_ent_r, w_ent_b;

    assign w_cmd_wr = data_write & (address == ADDR_CMD);
    // Pop when the engine is ready for the next command: idle, or finishing
    // the last pixel of the current one.
    assign w_pop    = ~w_empty &
                      ((state_q == ST_IDLE) |
                       ((state_q == ST_SEND) & pix_ready & (remain_q == '0)));
    assign w_drop   = w_cmd_wr & w_full & ~w_pop;
    assign w_wdata  = {g_q, r_q, b_q, data_in[CNT_W-1:0], data_in[7]};

    ws2812b_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_cmd_wr),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_ent_g = entry_q[RGB_OFF+16 +: 8];
    assign w_ent_r = entry_q[RGB_OFF+8  +: 8];
    assign w_ent_b = entry_q[RGB_OFF    +: 8];

`ifdef WS2812B_FEED_BRIGHTNESS_EN
    logic [7:0] bright_q;

    // c * (BRIGHT+1) fits in 16 bits; the top byte is the scaled channel.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, c} * ({8'h00, b} + 16'd1);
        return p[15:8];
    endfunction

    assign w_load_rgb = {scale(w_ent_g, bright_q),
                         scale(w_ent_r, bright_q),
                         scale(w_ent_b, bright_q)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 8'hFF;
        end else if (data_write && address == ADDR_BRIGHT) begin
            bright_q <= data_in;
        end
    end
`else
    assign w_load_rgb = {w_ent_g, w_ent_r, w_ent_b};
`endif

    // Staging registers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q   <= '0;
            r_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (data_write && address == ADDR_G) g_q <= data_in;
            if (data_write && address == ADDR_R) r_q <= data_in;
            if (data_write && address == ADDR_B) b_q <= data_in;
            if (w_drop) begin
                ovf_q <= 1'b1;
            end else if (data_write && address == ADDR_CLR && data_in[0]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Engine: the popped head is parked in entry_q, then LOAD turns it into
    // the registered pixel outputs so they never glitch during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            remain_q    <= '0;
            cur_latch_q <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_latch_q <= 1'b0;
        end else begin
            if (w_pop) entry_q <= w_rdata;
            case (state_q)
                ST_IDLE: begin
                    pix_valid_q <= 1'b0;
                    pix_latch_q <= 1'b0;
                    if (!w_empty) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    pix_data_q  <= w_load_rgb;
                    remain_q    <= entry_q[OFF_CNT +: CNT_W];
                    cur_latch_q <= entry_q[OFF_LATCH];
                    pix_latch_q <= entry_q[OFF_LATCH] & (entry_q[OFF_CNT +: CNT_W] == '0);
                    pix_valid_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (pix_ready) begin
                        if (remain_q != '0) begin
                            remain_q    <= remain_q - CNT_W'(1);
                            pix_latch_q <= cur_latch_q & (remain_q == CNT_W'(1));
                        end else begin
                            pix_valid_q <= 1'b0;
                            pix_latch_q <= 1'b0;
                            state_q     <= w_empty ? ST_IDLE : ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pix_valid_q <= 1'b0;
                    pix_latch_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_latch = pix_latch_q;

    assign w_level32   = 32'(w_level);
    assign w_level_sat = (w_level32 > 32'd7) ? 3'd7 : w_level32[2:0];

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_G:      data_out = g_q;
            ADDR_R:      data_out = r_q;
            ADDR_B:      data_out = b_q;
            ADDR_STATUS: data_out = {ovf_q, w_full, w_empty,
                                     (state_q != ST_IDLE) | ~w_empty,
                                     1'b0, w_level_sat};
`ifdef WS2812B_FEED_BRIGHTNESS_EN
            ADDR_BRIGHT: data_out = bright_q;
`endif
            default:     data_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ws2812b_pixel_feeder                                       |
// | Purpose  : Directed self-checking bench for ws2812b_pixel_feeder.        |
// |            Brightness checks run when WS2812B_FEED_BRIGHTNESS_EN is set. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ws2812b_pixel_feeder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  address;
    logic [7:0]  data_in;
    logic        data_write;
    logic [7:0]  data_out;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_latch;
    logic        pix_ready;

    int n_checks = 0;
    int n_pass   = 0;

    ws2812b_pixel_feeder #(
        .FIFO_DEPTH (4),
        .CNT_W      (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_in    (data_in),
        .data_write (data_write),
        .data_out   (data_out),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_latch  (pix_latch),
        .pix_ready  (pix_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called 1 time unit after a rising edge; the write lands on the next edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk); #1;
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !pix_valid; i++) next_cycle();
        check(tag, {31'd0, pix_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    logic [7:0]  v;
    logic [23:0] d_snap;
    logic        l_snap;
    int          pixels;

    initial begin
        rst_n      = 1'b0;
        address    = 4'h0;
        data_in    = 8'h00;
        data_write = 1'b0;
        pix_ready  = 1'b0;
        #12;
        // Reset state
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_data", {8'd0, pix_data}, 32'd0);
        rd(4'h3, v);
        check("rst_status", {24'd0, v}, 32'h20);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // 1: single pixel, latency N+3
        wr(4'h0, 8'h10);
        wr(4'h1, 8'h20);
        wr(4'h2, 8'h30);
        wr(4'h3, 8'h00);                      // cycle N
        check("t1_n1_valid", {31'd0, pix_valid}, 32'd0);
        next_cycle();
        check("t1_n2_valid", {31'd0, pix_valid}, 32'd0);
        next_cycle();
        check("t1_n3_valid", {31'd0, pix_valid}, 32'd1);
        check("t1_data", {8'd0, pix_data}, 32'h102030);
        check("t1_latch", {31'd0, pix_latch}, 32'd0);
        pix_ready = 1'b1;
        next_cycle();
        pix_ready = 1'b0;
        check("t1_done_valid", {31'd0, pix_valid}, 32'd0);
        next_cycle();
        rd(4'h3, v);
        check("t1_status_idle", {24'd0, v}, 32'h20);

        // 2: count 2 with latch, serializer holds off a cycle before each accept
        wr(4'h3, 8'h82);
        pixels = 0;
        for (int cyc = 0; cyc < 60 && pixels < 3; cyc++) begin
            if (pix_valid) begin
                d_snap = pix_data;
                l_snap = pix_latch;
                next_cycle();
                check("t2_stable", {7'd0, pix_valid, pix_data}, {7'd0, 1'b1, d_snap});
                check("t2_latch_stable", {31'd0, pix_latch}, {31'd0, l_snap});
                check("t2_data", {8'd0, pix_data}, 32'h102030);
                check("t2_latch", {31'd0, pix_latch}, (pixels == 2) ? 32'd1 : 32'd0);
                pix_ready = 1'b1;
                next_cycle();
                pix_ready = 1'b0;
                pixels++;
            end else begin
                next_cycle();
            end
        end
        check("t2_pixel_count", pixels, 32'd3);
        next_cycle();
        next_cycle();
        check("t2_no_extra", {31'd0, pix_valid}, 32'd0);

        // 3: stalled engine, overflow and clear
        wr(4'h0, 8'hAA);
        wr(4'h3, 8'h00);
        wait_valid("t3_first_loaded");
        for (int i = 0; i < 5; i++) wr(4'h3, 8'h05);
        rd(4'h3, v);
        check("t3_status_ovf", {24'd0, v}, 32'hD4);
        wr(4'hF, 8'h01);
        rd(4'h3, v);
        check("t3_status_clr", {24'd0, v}, 32'h54);

        // 4: push while full in the same cycle as the engine pops
        address    = 4'h3;
        data_in    = 8'h01;
        data_write = 1'b1;
        pix_ready  = 1'b1;
        next_cycle();
        data_write = 1'b0;
        pix_ready  = 1'b0;
        check("t4_valid_drop", {31'd0, pix_valid}, 32'd0);
        rd(4'h3, v);
        check("t4_status", {24'd0, v}, 32'h54);
        next_cycle();
        check("t4_next_data", {8'd0, pix_data}, 32'hAA2030);
        wr(4'h0, 8'h55);
        check("t4_inflight", {8'd0, pix_data}, 32'hAA2030);

        // Register 4: absent in the default build, BRIGHT otherwise
        rd(4'h4, v);
`ifdef WS2812B_FEED_BRIGHTNESS_EN
        check("bright_reset", {24'd0, v}, 32'hFF);
`else
        check("reg4_absent", {24'd0, v}, 32'h00);
`endif
        rd(4'h7, v);
        check("reg7_zero", {24'd0, v}, 32'h00);

        // 5: reset mid-SEND on the 2nd of 4 pixels
        do_reset();
        wr(4'h0, 8'h01);
        wr(4'h1, 8'h02);
        wr(4'h2, 8'h03);
        wr(4'h3, 8'h03);
        wait_valid("t5_valid");
        pix_ready = 1'b1;
        next_cycle();
        pix_ready = 1'b0;
        check("t5_second_valid", {31'd0, pix_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, pix_valid}, 32'd0);
        check("t5_async_data", {8'd0, pix_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        rd(4'h3, v);
        check("t5_status", {24'd0, v}, 32'h20);
        rd(4'h0, v);
        check("t5_g_zero", {24'd0, v}, 32'h00);
        next_cycle();
        check("t5_stays_idle", {31'd0, pix_valid}, 32'd0);

`ifdef WS2812B_FEED_BRIGHTNESS_EN
        // 6: brightness scaling sampled at LOAD
        wr(4'h4, 8'h7F);
        wr(4'h0, 8'hFF);
        wr(4'h1, 8'h80);
        wr(4'h2, 8'h01);
        wr(4'h3, 8'h00);
        wait_valid("t6_valid_half");
        check("t6_scaled", {8'd0, pix_data}, 32'h7F4000);
        pix_ready = 1'b1;
        next_cycle();
        pix_ready = 1'b0;
        wr(4'h4, 8'hFF);
        wr(4'h3, 8'h00);
        wait_valid("t6_valid_full");
        check("t6_identity", {8'd0, pix_data}, 32'hFF8001);
        pix_ready = 1'b1;
        next_cycle();
        pix_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
